regfile_mp: RTL

Parametrised multi-port register file for the pipelined core, replacing the fixed 8×16 register file. It provides two combinational read ports, two prioritised write ports, an optional hard-wired zero register, an optional write-to-read bypass, a sequential clear engine and a debug readout port. It sits between decode (reads), writeback (writes) and the board debug logic.

---
 rtl/regfile_mp_if.sv | 40 ++++
 rtl/regfile_mp.sv | 119 +++++++++++
 2 files changed

// File: rtl/regfile_mp_if.sv
// Bus interface for regfile_mp: two read ports, two write ports, the sweep
// clear handshake and the debug readout.
//   master : decode/writeback/debug side (drives addresses, data, requests)
//   slave  : the register file itself
interface regfile_mp_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
);
  logic [ADDR_W-1:0] rd_addr_a;
  logic [DATA_W-1:0] rd_data_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_b;
  logic              wr_en_0;
  logic [ADDR_W-1:0] wr_addr_0;
  logic [DATA_W-1:0] wr_data_0;
  logic              wr_en_1;
  logic [ADDR_W-1:0] wr_addr_1;
  logic [DATA_W-1:0] wr_data_1;
  logic              clr_req;
  logic              clr_busy;
  logic              clr_done;
  logic [ADDR_W-1:0] dbg_sel;
  logic [DATA_W-1:0] dbg_data;

  modport master (
    output rd_addr_a, rd_addr_b,
    output wr_en_0, wr_addr_0, wr_data_0,
    output wr_en_1, wr_addr_1, wr_data_1,
    output clr_req, dbg_sel,
    input  rd_data_a, rd_data_b, clr_busy, clr_done, dbg_data
  );

  modport slave (
    input  rd_addr_a, rd_addr_b,
    input  wr_en_0, wr_addr_0, wr_data_0,
    input  wr_en_1, wr_addr_1, wr_data_1,
    input  clr_req, dbg_sel,
    output rd_data_a, rd_data_b, clr_busy, clr_done, dbg_data
  );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears every register, aborts sweep)
//   bus   : regfile_mp_if slave modport
//     rd_addr_a/rd_data_a, rd_addr_b/rd_data_b : combinational read ports
//     wr_en_0/wr_addr_0/wr_data_0               : write port 0
//     wr_en_1/wr_addr_1/wr_data_1               : write port 1 (wins on same address)
//     clr_req/clr_busy/clr_done                 : sequential sweep clear
//     dbg_sel/dbg_data                          : stored value readout (never bypassed)
// Parameters: DATA_W, ADDR_W (DEPTH = 2**ADDR_W), ZERO_REG (reg 0 hard-wired to 0).
// Optional feature: define RF_BYPASS_EN to forward same-cycle write data to reads.
module regfile_mp #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 3,
  parameter bit          ZERO_REG = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  regfile_mp_if.slave bus
);

  localparam int unsigned       DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              busy;

  logic [DATA_W-1:0] mem [DEPTH];

  logic we0, we1;
  logic zero_a, zero_b, zero_dbg;

  assign busy = (state_q == CLEAR);

  // Writes are dropped during a sweep and, with ZERO_REG, when aimed at r0.
  assign we0 = bus.wr_en_0 && !busy && !(ZERO_REG && (bus.wr_addr_0 == '0));
  assign we1 = bus.wr_en_1 && !busy && !(ZERO_REG && (bus.wr_addr_1 == '0));

  assign zero_a   = ZERO_REG && (bus.rd_addr_a == '0);
  assign zero_b   = ZERO_REG && (bus.rd_addr_b == '0);
  assign zero_dbg = ZERO_REG && (bus.dbg_sel == '0);

  // Clear FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Clear FSM next state; done_d rises on the edge that clears the last register
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST_IDX) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Storage array; port 1 is assigned last so it wins on an address collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (busy) begin
      mem[cnt_q] <= '0;
    end else begin
      if (we0) mem[bus.wr_addr_0] <= bus.wr_data_0;
      if (we1) mem[bus.wr_addr_1] <= bus.wr_data_1;
    end
  end

`ifdef RF_BYPASS_EN
  // we0/we1 already exclude sweep cycles and the hard-wired zero register
  assign bus.rd_data_a = zero_a                                 ? '0 :
                         (we1 && (bus.wr_addr_1 == bus.rd_addr_a)) ? bus.wr_data_1 :
                         (we0 && (bus.wr_addr_0 == bus.rd_addr_a)) ? bus.wr_data_0 :
                         mem[bus.rd_addr_a];
  assign bus.rd_data_b = zero_b                                 ? '0 :
                         (we1 && (bus.wr_addr_1 == bus.rd_addr_b)) ? bus.wr_data_1 :
                         (we0 && (bus.wr_addr_0 == bus.rd_addr_b)) ? bus.wr_data_0 :
                         mem[bus.rd_addr_b];
`else
  assign bus.rd_data_a = zero_a ? '0 : mem[bus.rd_addr_a];
  assign bus.rd_data_b = zero_b ? '0 : mem[bus.rd_addr_b];
`endif

  assign bus.dbg_data = zero_dbg ? '0 : mem[bus.dbg_sel];
  assign bus.clr_busy = busy;
  assign bus.clr_done = done_q;

endmodule
